// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART between on-chip logic and the serial pins; `UART_PARITY_EN adds an even-parity bit.
// TX drives the start bit on the edge after an accepted trigger; triggers while busy are dropped. RX flags ~9.5 bit times after the start edge.
module uart_top #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_trig,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_busy,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_flag,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int BIT_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW      = $clog2(BIT_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] MID  = CW'(BIT_DIV / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t        tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_bit_n;
`ifdef UART_PARITY_EN
    logic          tx_par, tx_par_n;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_bit_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_bit_n   = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        if (tx_state == IDLE) begin
            if (uart_trig) begin
                tx_state_n = START;
                tx_cnt_n   = '0;
                tx_shift_n = uart_tx_data;
`ifdef UART_PARITY_EN
                tx_par_n   = ^uart_tx_data;
`endif
            end
        end else if (tx_cnt != LAST) begin
            tx_cnt_n = tx_cnt + 1'b1;
        end else begin
            tx_cnt_n = '0;
            case (tx_state)
                START: begin
                    tx_state_n = DATA;
                    tx_idx_n   = '0;
                end
                DATA: begin
                    tx_shift_n = tx_shift >> 1;
                    tx_idx_n   = tx_idx + 1'b1;
`ifdef UART_PARITY_EN
                    if (tx_idx == 3'd7) tx_state_n = PARITY;
`else
                    if (tx_idx == 3'd7) tx_state_n = STOP;
`endif
                end
                PARITY:  tx_state_n = STOP;
                default: tx_state_n = IDLE;
            endcase
        end
        // The output bit is registered from the next state so uart_tx is a clean flop output.
        case (tx_state_n)
            START:   tx_bit_n = 1'b0;
            DATA:    tx_bit_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_bit_n = tx_par_n;
`endif
            default: tx_bit_n = 1'b1;
        endcase
    end

    assign uart_tx_busy = (tx_state != IDLE);

    // Two synchroniser flops, third flop only keeps history for falling-edge detection.
    logic rx_s1, rx_s2, rx_s3;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [7:0]    rx_data_n;
    logic          rx_flag_n;
    logic          rx_par_ok;
`ifdef UART_PARITY_EN
    logic          rx_perr, rx_perr_n;
    assign rx_par_ok = ~rx_perr;
`else
    assign rx_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            uart_rx_data <= '0;
            uart_rx_flag <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr      <= 1'b0;
`endif
        end else begin
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_idx       <= rx_idx_n;
            rx_shift     <= rx_shift_n;
            uart_rx_data <= rx_data_n;
            uart_rx_flag <= rx_flag_n;
`ifdef UART_PARITY_EN
            rx_perr      <= rx_perr_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_data_n  = uart_rx_data;
        rx_flag_n  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_n  = rx_perr;
`endif
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_s3 && !rx_s2) rx_state_n = START;
            end
            START: begin
                if (rx_cnt == MID) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_idx_n   = rx_idx + 1'b1;
`ifdef UART_PARITY_EN
                    if (rx_idx == 3'd7) rx_state_n = PARITY;
`else
                    if (rx_idx == 3'd7) rx_state_n = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_perr_n  = rx_s2 ^ (^rx_shift);
                    rx_state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n = '0;
                    if (!rx_s2) begin
                        rx_state_n = WAIT_HIGH;
                    end else begin
                        rx_state_n = IDLE;
                        if (rx_par_ok) begin
                            rx_data_n = rx_shift;
                            rx_flag_n = 1'b1;
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                rx_cnt_n = '0;
                if (rx_s2) rx_state_n = IDLE;
            end
            default: begin
                rx_cnt_n   = '0;
                rx_state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top, run at a reduced line rate (50 MHz / 3 Mbaud -> 16.67, rounded to 17 clocks per bit).
module tb_uart_top;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 3_000_000;
    localparam int BD       = 17;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT_LO = (19 * BD + 5) / 2;
    localparam int LAT_HI = (19 * BD + 8) / 2;
    localparam int GLITCH = BD / 2 - 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       uart_trig = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       uart_tx_busy, uart_rx_flag, uart_tx;
    logic [7:0] uart_rx_data;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;
    logic       uart_rx;
    assign uart_rx = loop ? uart_tx : rx_drv;

    uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rstn(rstn), .uart_trig(uart_trig), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data), .uart_rx_flag(uart_rx_flag),
        .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; int t; } flag_t;
    flag_t got_q[$];
    int    long_pulse = 0;
    logic  prev_flag = 1'b0;
    always @(negedge clk) begin
        if (uart_rx_flag) got_q.push_back('{d: uart_rx_data, t: cyc});
        if (uart_rx_flag && prev_flag) long_pulse <= long_pulse + 1;
        prev_flag <= uart_rx_flag;
    end

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       par_bad;
        logic       glitch;
        logic       exp_flag;
        logic [7:0] exp_data;
    } rx_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial frame definition: start 0, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input logic par_bad, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return (^d) ^ par_bad;
`endif
        return stop;
    endfunction

    // Transmit one byte and compare uart_tx/busy against the ideal waveform on every clock.
    task automatic send(input logic [7:0] d, input int spoil_at, output int t0);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (uart_tx_busy && n < 4 * NBITS * BD) begin
            step(1);
            n++;
        end
        chk("tx_idle_before_trigger", uart_tx_busy, 0);
        uart_tx_data = d;
        uart_trig = 1'b1;
        step(1);
        uart_trig = 1'b0;
        t0 = cyc;
        for (int j = 0; j < NBITS * BD; j++) begin
            if (uart_tx !== frame_bit(d, 1'b1, 1'b0, j / BD) || uart_tx_busy !== 1'b1) begin
                if (bad == 0)
                    $display("FAIL tx_wave byte 0x%0h clk %0d: got tx=%b busy=%b, want tx=%b busy=1",
                             d, j, uart_tx, uart_tx_busy, frame_bit(d, 1'b1, 1'b0, j / BD));
                bad++;
            end
            if (j == spoil_at) begin
                uart_tx_data = ~d;
                uart_trig = 1'b1;
            end
            if (j == spoil_at + 3) uart_trig = 1'b0;
            step(1);
        end
        tests++;
        if (bad != 0) fails++;
        chk("tx_busy_low_after_frame", uart_tx_busy, 0);
        chk("tx_idle_high_after_frame", uart_tx, 1);
    endtask

    task automatic drive_rx(input rx_vec_t v, output int t0);
        t0 = cyc;
        if (v.glitch) begin
            rx_drv = 1'b0;
            step(GLITCH);
        end else begin
            for (int k = 0; k < NBITS; k++) begin
                rx_drv = frame_bit(v.dat, v.stop, v.par_bad, k);
                step(BD);
            end
            if (!v.stop) step(2 * BD);
        end
        rx_drv = 1'b1;
        step(3 * BD);
    endtask

    rx_vec_t vecs[8];
    int      nv;

    initial begin
        int t0;
        int hi;

        nv = 0;
        vecs[nv++] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
        vecs[nv++] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[nv++] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[nv++] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[nv++] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[nv++] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81};
`ifdef UART_PARITY_EN
        vecs[nv++] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
`endif
        vecs[nv++] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E};

        #100;
        chk("reset_tx", uart_tx, 1);
        chk("reset_busy", uart_tx_busy, 0);
        chk("reset_rx_data", uart_rx_data, 8'h00);
        chk("reset_rx_flag", uart_rx_flag, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step(5);

        send(8'hA5, -1, t0);

        // A trigger in the middle of a frame must neither corrupt it nor start another one.
        send(8'h3C, 4 * BD, t0);
        hi = 0;
        for (int i = 0; i < 2 * NBITS * BD; i++) begin
            if (uart_tx_busy) hi++;
            step(1);
        end
        chk("no_second_frame_busy_cycles", hi, 0);
        chk("no_flag_without_loopback", got_q.size(), 0);

        for (int i = 0; i < nv; i++) begin
            got_q.delete();
            drive_rx(vecs[i], t0);
            chk("rx_vec_flag_count", got_q.size(), vecs[i].exp_flag ? 1 : 0);
            if (vecs[i].exp_flag && got_q.size() > 0) begin
                chk("rx_vec_flag_data", got_q[0].d, vecs[i].exp_data);
                chk_range("rx_vec_latency", got_q[0].t - t0, LAT_LO, LAT_HI);
            end
            chk("rx_vec_data_held", uart_rx_data, vecs[i].exp_data);
        end

        // Loopback: incrementing bytes through the 0xFF -> 0x00 wrap, then random bytes, with random gaps.
        loop = 1'b1;
        for (int i = 0; i < 258 + 16; i++) begin
            logic [7:0] d;
            int gap;
            d = (i < 258) ? 8'(i) : 8'($urandom_range(0, 255));
            got_q.delete();
            send(d, -1, t0);
            chk("lb_flag_count", got_q.size(), 1);
            if (got_q.size() > 0) begin
                chk("lb_rx_data", got_q[0].d, d);
                chk_range("lb_latency", got_q[0].t - t0, LAT_LO, LAT_HI);
            end
            gap = $urandom_range(0, 3);
            step(gap);
        end

        // Reset in the middle of a looped-back frame.
        got_q.delete();
        uart_tx_data = 8'h5A;
        uart_trig = 1'b1;
        step(1);
        uart_trig = 1'b0;
        step(4 * BD);
        chk("busy_before_reset", uart_tx_busy, 1);
        #3 rstn = 1'b0;
        #1;
        chk("reset_mid_tx_line", uart_tx, 1);
        chk("reset_mid_tx_busy", uart_tx_busy, 0);
        chk("reset_mid_rx_data", uart_rx_data, 8'h00);
        #5 rstn = 1'b1;
        @(posedge clk);
        #1;
        step(3 * NBITS * BD);
        chk("reset_mid_no_flag", got_q.size(), 0);
        chk("reset_mid_stays_idle", uart_tx_busy, 0);
        chk("reset_mid_line_high", uart_tx, 1);

        chk("rx_flag_single_cycle", long_pulse, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
